// File: rtl/hilo_div_unit_if.sv
// Handshake and result bundle between the EX-stage issue logic and hilo_div_unit.
// The master drives the operands and flow control; the slave (divider) returns busy and the HI/LO result.
interface hilo_div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  start;
  logic                  is_signed;
  logic [DATA_W-1:0]     dividend;
  logic [DATA_W-1:0]     divisor;
  logic                  cancel;
  logic                  wb_ready;
  logic                  busy;
  logic                  hl_valid;
  logic [2*DATA_W-1:0]   hl_data;

  modport master (
    output start, is_signed, dividend, divisor, cancel, wb_ready,
    input  busy, hl_valid, hl_data
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel, wb_ready,
    output busy, hl_valid, hl_data
  );
endinterface

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Result is {remainder, quotient} for HI/LO, held in DONE until writeback accepts it.
module hilo_div_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic          clk,
  input  logic          rst,
  hilo_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     dvs_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sign_a_q;
  logic                  sign_b_q;
  logic                  signed_q;
  logic                  div0_q;
  logic [2*DATA_W-1:0]   hl_data_q;

  logic                  accept;
  logic                  last_step;
  logic                  a_neg;
  logic                  b_neg;
  logic                  div0;
  logic [DATA_W-1:0]     abs_a;
  logic [DATA_W-1:0]     abs_b;
  logic [DATA_W:0]       rem_shift;
  logic [DATA_W-1:0]     rem_sub;
  logic                  trial_ok;
  logic [DATA_W-1:0]     rem_step;
  logic [DATA_W-1:0]     quo_step;
  logic                  fix_q;
  logic                  fix_r;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic                  busy_c;
  logic                  hl_valid_c;

  assign accept    = (state == IDLE) && bus.start && !bus.cancel;
  assign last_step = (cnt_q == CNT_W'(ITER - 1));

  assign a_neg = bus.is_signed & bus.dividend[DATA_W-1];
  assign b_neg = bus.is_signed & bus.divisor[DATA_W-1];
  assign abs_a = a_neg ? -bus.dividend : bus.dividend;
  assign abs_b = b_neg ? -bus.divisor : bus.divisor;
  assign div0  = (bus.divisor == '0);

  // The shifted partial remainder can reach 33 bits; when it is at least D the
  // true difference is below D, so a 32-bit subtraction is exact.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign trial_ok  = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[DATA_W-1:0] - dvs_q;
  assign rem_step  = trial_ok ? rem_sub : rem_shift[DATA_W-1:0];
  assign quo_step  = {quo_q[DATA_W-2:0], trial_ok};

  assign fix_q   = signed_q && !div0_q && (sign_a_q ^ sign_b_q);
  assign fix_r   = signed_q && !div0_q && sign_a_q;
  assign quo_fix = fix_q ? -quo_step : quo_step;
  assign rem_fix = fix_r ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (bus.cancel)     state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (bus.cancel || bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c     = 1'b0;
    hl_valid_c = 1'b0;
    case (state)
      CALC: busy_c = 1'b1;
      DONE: begin
        busy_c     = 1'b1;
        hl_valid_c = 1'b1;
      end
      default: ;
    endcase
  end

  // With a zero divisor the raw dividend is loaded, so the plain iteration
  // leaves it untouched in R and fills Q with ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      signed_q  <= 1'b0;
      div0_q    <= 1'b0;
      hl_data_q <= '0;
    end else if (accept) begin
      rem_q    <= '0;
      quo_q    <= div0 ? bus.dividend : abs_a;
      dvs_q    <= abs_b;
      cnt_q    <= '0;
      sign_a_q <= a_neg;
      sign_b_q <= b_neg;
      signed_q <= bus.is_signed;
      div0_q   <= div0;
    end else if (state == CALC && !bus.cancel) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        hl_data_q <= {rem_fix, quo_fix};
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.hl_valid = hl_valid_c;
  assign bus.hl_data  = hl_data_q;
endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative 32-bit radix-2 divider in the EX stage. Serves MIPS DIV and DIVU.
- Produces the 64-bit {remainder, quotient} pair that travels through MEM/WB. The register file writes that pair into HI/LO on hl_write_enable_from_wb.
- bits [63:32] go to HI (remainder); bits [31:0] go to LO (quotient).
- Exposes busy so ID can stall HI/LO readers and new divides until the result retires.

Parameters:
- DATA_W, 32, operand width; hl_data is 2*DATA_W.
- ITER, 32, number of iteration cycles; must equal DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  issue a divide; sampled only in IDLE.
- is_signed  input  1  1 = DIV (signed), 0 = DIVU; captured with start.
- dividend  input  32  rs operand; captured with start.
- divisor  input  32  rt operand; captured with start.
- cancel  input  1  pipeline flush (exception/eret); aborts the operation.
- wb_ready  input  1  downstream accepts the result this cycle.
- busy  output  1  high in CALC and DONE.
- hl_valid  output  1  result valid; this is the HI/LO write strobe toward WB.
- hl_data  output  64  {remainder, quotient}.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, hl_valid=0, hl_data=0, iteration counter=0.
- States:
  - IDLE: start=1 and cancel=0 latches |dividend|, |divisor| (absolute values only when is_signed=1), both sign bits, is_signed, and a div0 flag; goes to CALC with counter=0.
  - CALC: one restoring step per cycle.
    - partial remainder {R,Q} shifts left 1; trial = R - D (33-bit).
    - if trial is non-negative: R=trial[31:0], Q[0]=1; else Q[0]=0.
    - counter increments; after the 32nd step (counter==31) goes to DONE.
  - DONE: hl_valid=1, hl_data stable. wb_ready=1 goes to IDLE on the next edge; otherwise stays in DONE holding the data.
- Latency: start sampled at edge E0. CALC occupies edges E1..E32. hl_valid is first high in the cycle after E32 (33 cycles after issue).
- Sign fix, applied when entering DONE and only if is_signed=1:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^32, so 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide by zero (div0): full 33-cycle latency still applies; result is q=0xFFFFFFFF, r=original dividend unmodified; no sign fix.
- start while busy: ignored; ID must stall on busy.
- cancel=1: in CALC or DONE, the next state is IDLE with hl_valid=0. cancel overrides start and wb_ready in the same cycle. hl_data keeps its last value (don't-care while hl_valid=0).
- hl_valid is never asserted for a cancelled operation.
- Back-to-back: start may be accepted in the first IDLE cycle after DONE+wb_ready; no start is accepted in the handoff cycle itself.
- Operand inputs are don't-care outside the start cycle.

Test Plan:
- Unsigned: start, is_signed=0, 100/7 -> hl_valid exactly 33 cycles later, hl_data=0x00000002_0000000E; busy high for 33 cycles.
- Signed: -7/2 (0xFFFFFFF9/0x00000002) -> hl_data=0xFFFFFFFF_FFFFFFFD. Also 0x80000000/0xFFFFFFFF signed -> 0x00000000_80000000. Also unsigned 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
- Divide by zero: signed 0x12345678/0 -> after 33 cycles, hl_data=0x12345678_FFFFFFFF.
- Backpressure: hold wb_ready=0 for 5 cycles after done -> hl_valid and hl_data stable for all 5 cycles. Then wb_ready=1 -> IDLE, busy=0 next cycle; an extra start during DONE is ignored.
- Cancel: assert cancel at CALC cycle 10 with start=1 simultaneously -> IDLE next cycle, busy=0, no hl_valid pulse. A following 9/3 returns 0x00000000_00000003.
- Async reset mid-CALC: drop rst between clock edges -> busy, hl_valid and hl_data go to 0 immediately. After release the unit accepts a new start normally.
